// File: rtl/datapath_sequencer_pkg.sv
// Shared definitions for the LEGv8 datapath sequencer.
// Holds the FSM state encoding, the decoded instruction classes, the
// opcode constants recognised by the decoder, the ALU function-select
// encodings and the memory wait limit.
package datapath_sequencer_pkg;

  localparam int INSTR_W = 32;
  localparam int CONST_W = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    MEM    = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_RTYPE   = 3'd1,
    CLS_ITYPE   = 3'd2,
    CLS_LOAD    = 3'd3,
    CLS_STORE   = 3'd4
  } class_e;

  // 11-bit opcodes, instr[31:21]
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  // 10-bit opcodes, instr[31:22]
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;

  // ALU function selects
  localparam logic [4:0]  FS_AND = 5'b00000;
  localparam logic [4:0]  FS_ORR = 5'b00100;
  localparam logic [4:0]  FS_ADD = 5'b01000;
  localparam logic [4:0]  FS_SUB = 5'b01001;

  // Memory wait count at which an outstanding request is abandoned
  localparam logic [3:0]  WAIT_MAX = 4'd15;

endpackage

// File: rtl/datapath_sequencer_if.sv
// Bundle of the sequencer's instruction handshake, memory handshake and
// datapath control signals.
//   master : the sequencer (drives instr_ready, memory request, controls)
//   slave  : the environment (drives instruction, status, mem_ack)
interface datapath_sequencer_if;
  import datapath_sequencer_pkg::*;

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [3:0]         status;
  logic               mem_req;
  logic               mem_we;
  logic               mem_ack;
  logic [4:0]         DA;
  logic [4:0]         SA;
  logic [4:0]         SB;
  logic               W;
  logic [4:0]         FS;
  logic               C0;
  logic               Bsel;
  logic               EN_ALU;
  logic               EN_B;
  logic               EN_ADDR_ALU;
  logic [CONST_W-1:0] constant;
  logic [3:0]         flags;
  logic               done;
  logic               fault;

  modport master (
    input  instr_valid, instr, status, mem_ack,
    output instr_ready, mem_req, mem_we, DA, SA, SB, W, FS, C0, Bsel,
           EN_ALU, EN_B, EN_ADDR_ALU, constant, flags, done, fault
  );

  modport slave (
    output instr_valid, instr, status, mem_ack,
    input  instr_ready, mem_req, mem_we, DA, SA, SB, W, FS, C0, Bsel,
           EN_ALU, EN_B, EN_ADDR_ALU, constant, flags, done, fault
  );

endinterface

// File: rtl/datapath_sequencer_decode.sv
// legv8_decode: purely combinational LEGv8 instruction classifier.
//   instr_i     : latched instruction word
//   cls_o       : R-type / I-type / load / store / illegal
//   fs_o, c0_o  : ALU function select and carry-in
//   bsel_o      : 1 selects constant_o as ALU operand B
//   set_flags_o : instruction updates NZCV (ADDS/SUBS)
//   constant_o  : zero-extended imm12 (I-type) or sign-extended imm9 (D-type)
module legv8_decode
  import datapath_sequencer_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output class_e             cls_o,
  output logic [4:0]         fs_o,
  output logic               c0_o,
  output logic               bsel_o,
  output logic               set_flags_o,
  output logic [CONST_W-1:0] constant_o
);

  logic [10:0] op11;
  logic [9:0]  op10;
  logic        unused_reg_fields;

  assign op11 = instr_i[31:21];
  assign op10 = instr_i[31:22];
  // Register fields are routed by the sequencer, not the decoder
  assign unused_reg_fields = ^instr_i[9:0];

  always_comb begin
    cls_o       = CLS_ILLEGAL;
    fs_o        = FS_AND;
    c0_o        = 1'b0;
    bsel_o      = 1'b0;
    set_flags_o = 1'b0;
    constant_o  = '0;
    case (op11)
      OP_ADD:  begin cls_o = CLS_RTYPE; fs_o = FS_ADD; end
      OP_SUB:  begin cls_o = CLS_RTYPE; fs_o = FS_SUB; c0_o = 1'b1; end
      OP_AND:  begin cls_o = CLS_RTYPE; fs_o = FS_AND; end
      OP_ORR:  begin cls_o = CLS_RTYPE; fs_o = FS_ORR; end
      OP_ADDS: begin cls_o = CLS_RTYPE; fs_o = FS_ADD; set_flags_o = 1'b1; end
      OP_SUBS: begin
        cls_o = CLS_RTYPE; fs_o = FS_SUB; c0_o = 1'b1; set_flags_o = 1'b1;
      end
      OP_LDUR, OP_STUR: begin
        cls_o      = (op11 == OP_LDUR) ? CLS_LOAD : CLS_STORE;
        fs_o       = FS_ADD;
        bsel_o     = 1'b1;
        constant_o = {{(CONST_W-9){instr_i[20]}}, instr_i[20:12]};
      end
      default: begin
        // I-type opcodes are only 10 bits wide, so check them last
        if (op10 == OP_ADDI || op10 == OP_SUBI) begin
          cls_o      = CLS_ITYPE;
          fs_o       = (op10 == OP_ADDI) ? FS_ADD : FS_SUB;
          c0_o       = (op10 == OP_SUBI);
          bsel_o     = 1'b1;
          constant_o = {{(CONST_W-12){1'b0}}, instr_i[21:10]};
        end
      end
    endcase
  end

endmodule

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: four-state LEGv8 control sequencer.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : instruction handshake, memory handshake, datapath controls,
//           registered NZCV flags and done/fault pulses
// Controls are Moore outputs of the registered state and latched
// instruction; only done and the load write-enable follow mem_ack.
module datapath_sequencer
  import datapath_sequencer_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  datapath_sequencer_if.master bus
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] instr_q;
  logic [3:0]         flags_q;
  logic [3:0]         wait_q, wait_d;
  logic               timeout;

  class_e             dec_cls;
  logic [4:0]         dec_fs;
  logic               dec_c0;
  logic               dec_bsel;
  logic               dec_set_flags;
  logic [CONST_W-1:0] dec_const;

  legv8_decode u_decode (
    .instr_i     (instr_q),
    .cls_o       (dec_cls),
    .fs_o        (dec_fs),
    .c0_o        (dec_c0),
    .bsel_o      (dec_bsel),
    .set_flags_o (dec_set_flags),
    .constant_o  (dec_const)
  );

  // Once the wait count saturates the request is abandoned this cycle
  assign timeout   = (wait_q == WAIT_MAX);
  assign bus.flags = flags_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      flags_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == IDLE && bus.instr_valid) instr_q <= bus.instr;
      if (state_q == EXEC && dec_set_flags)   flags_q <= bus.status;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE:   if (bus.instr_valid) state_d = DECODE;
      DECODE: begin
        case (dec_cls)
          CLS_RTYPE, CLS_ITYPE: state_d = EXEC;
          CLS_LOAD, CLS_STORE: begin
            state_d = MEM;
            wait_d  = '0;
          end
          default: state_d = IDLE;
        endcase
      end
      EXEC:   state_d = IDLE;
      MEM: begin
        if (timeout || bus.mem_ack) state_d = IDLE;
        else                        wait_d  = wait_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.instr_ready = 1'b0;
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.DA          = '0;
    bus.SA          = '0;
    bus.SB          = '0;
    bus.W           = 1'b0;
    bus.FS          = FS_AND;
    bus.C0          = 1'b0;
    bus.Bsel        = 1'b0;
    bus.EN_ALU      = 1'b0;
    bus.EN_B        = 1'b0;
    bus.EN_ADDR_ALU = 1'b0;
    bus.constant    = '0;
    bus.done        = 1'b0;
    bus.fault       = 1'b0;
    case (state_q)
      IDLE:   bus.instr_ready = 1'b1;
      DECODE: bus.fault = (dec_cls == CLS_ILLEGAL);
      EXEC: begin
        bus.SA       = instr_q[9:5];
        bus.SB       = instr_q[20:16];
        bus.DA       = instr_q[4:0];
        bus.W        = 1'b1;
        bus.EN_ALU   = 1'b1;
        bus.done     = 1'b1;
        bus.FS       = dec_fs;
        bus.C0       = dec_c0;
        bus.Bsel     = dec_bsel;
        bus.constant = dec_const;
      end
      MEM: begin
        if (timeout) begin
          bus.fault = 1'b1;
        end else begin
          bus.SA          = instr_q[9:5];
          bus.Bsel        = dec_bsel;
          bus.constant    = dec_const;
          bus.FS          = dec_fs;
          bus.C0          = dec_c0;
          bus.EN_ADDR_ALU = 1'b1;
          bus.mem_req     = 1'b1;
          bus.done        = bus.mem_ack;
          if (dec_cls == CLS_STORE) begin
            bus.mem_we = 1'b1;
            bus.SB     = instr_q[4:0];
            bus.EN_B   = 1'b1;
          end else begin
            // Load data is written back only when memory returns it
            bus.DA = instr_q[4:0];
            bus.W  = bus.mem_ack;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/datapath_sequencer.md
DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 Port: clock  in  1  rising-edge clock.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: instr_valid  in  1  instruction offered; instr_ready  out  1  sequencer accepts instruction.
REQ-005 Port: instr  in  32  LEGv8 instruction word.
REQ-006 Port: status  in  4  ALU flags from datapath.
REQ-007 Port: mem_req  out  1  memory request; mem_we  out  1  store when 1; mem_ack  in  1  memory completes request this cycle.
REQ-008 Port: DA, SA, SB  out  5 each; W  out  1; FS  out  5; C0  out  1; Bsel  out  1  (0 = register B, 1 = constant).
REQ-009 Port: EN_ALU, EN_B, EN_ADDR_ALU  out  1 each  tristate enables; constant  out  64  immediate to datapath.
REQ-010 Port: flags  out  4  registered NZCV; done  out  1  instruction retired pulse; fault  out  1  illegal or timeout pulse.

Function
REQ-011 States SHALL be IDLE, DECODE, EXEC, MEM, in that encoding order.
REQ-012 IDLE: instr_ready=1; on instr_valid, latch instr and go to DECODE; instr_ready SHALL be 0 in all other states.
REQ-013 DECODE (1 cycle): R-type ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, ADDS 10101011000 and SUBS 11101011000 go to EXEC.
REQ-014 DECODE: I-type ADDI 1001000100 and SUBI 1101000100 go to EXEC; D-type LDUR 11111000010 and STUR 11111000000 go to MEM.
REQ-015 DECODE: any other opcode SHALL pulse fault for 1 cycle and return to IDLE, with no W, enable or mem_req asserted.
REQ-016 EXEC (1 cycle): SA=Rn[9:5], SB=Rm[20:16], DA=Rd[4:0], W=1, EN_ALU=1, done=1; next state IDLE.
REQ-017 EXEC for I-type: Bsel=1; constant = zero-extended imm12[21:10].
REQ-018 FS/C0: AND=00000/0, ORR=00100/0, ADD=01000/0, SUB=01001/1.
REQ-019 flags SHALL load status at the end of EXEC for ADDS/SUBS only and hold otherwise.
REQ-020 MEM: SA=Rn, Bsel=1, constant = sign-extended imm9[20:12], FS=ADD, C0=0, EN_ADDR_ALU=1, mem_req=1; held until mem_ack or timeout.
REQ-021 LDUR: mem_we=0, DA=Rt[4:0]; W=1 only in the mem_ack cycle, loading from the data bus.
REQ-022 STUR: mem_we=1, SB=Rt, EN_B=1; W=0 throughout.
REQ-023 mem_ack cycle SHALL assert done and return to IDLE.
REQ-024 A 4-bit wait counter SHALL clear on entry to MEM and count while mem_ack=0; at count 15 without ack: fault pulse, mem_req drops, return to IDLE.
REQ-025 EN_ALU and EN_B SHALL never be 1 in the same cycle.
REQ-026 In IDLE/DECODE all enables, W, mem_req and mem_we SHALL be 0; constant=0.
REQ-027 Outputs SHALL be decoded from the registered state and latched instr (Moore), so the 1st EXEC/MEM cycle is stable.
REQ-028 Latency: R/I = 3 cycles from accept (IDLE, DECODE, EXEC); LDUR/STUR = 3 + wait cycles.
REQ-029 mem_ack outside MEM SHALL be ignored.

Reset
REQ-030 reset SHALL force IDLE, clear instr latch, flags=0, wait counter=0, done=0, fault=0 and all enables/W/mem_req=0, regardless of state (including mid-MEM).
REQ-031 The first instr_valid after reset deassertion SHALL be accepted on the next rising edge.

Structure
REQ-032 A shared package SHALL hold the state enum, the opcode constants and the FS encodings.
REQ-033 The decoder SHALL be one combinational sub-module, legv8_decode: instr in; class, FS, C0, Bsel, flag-set and constant out.

Verification
REQ-034 ADD X3,X1,X2 (0x8B020023) -> DA=3, SA=1, SB=2, FS=01000, W=1, EN_ALU=1, done in the 3rd cycle after accept.
REQ-035 ADDI X5,X5,#0xFFF -> Bsel=1, constant=0x0000000000000FFF; SUBS with status=1001 -> flags=1001, held through a later ADD.
REQ-036 LDUR X7,[X2,#-8], mem_ack after 3 wait cycles -> constant=0xFFFFFFFFFFFFFFF8, EN_ADDR_ALU=1, W=1 only in the ack cycle, DA=7.
REQ-037 STUR X4,[X1,#16], immediate ack -> mem_we=1, EN_B=1, SB=4, EN_ALU=0, W=0, done=1.
REQ-038 Opcode 0x00000000 -> fault pulse, no W; STUR with no ack -> fault after 15 wait cycles, back to IDLE with instr_ready=1.
REQ-039 reset asserted mid-MEM -> mem_req=0, state IDLE, flags=0 immediately.
